// File: rtl/range_persistence_filter.sv
// -----------------------------------------------------------------------------
// range_persistence_filter
//   Debounces the 2-bit range code from the range classifier. A new code is
//   committed only after HOLD_CYCLES consecutive valid samples of it, which
//   stops jitter when the classified number hovers near a bin edge.
//   Downstream logic reads only the committed range and the one-cycle
//   change pulse.
//
// Parameters
//   HOLD_CYCLES  matching valid samples needed to commit (2 .. 2**CNT_W-1)
//   CNT_W        width of the persistence counter
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous, active-high reset
//   sample_en     in   range_in is valid this cycle; all state holds when low
//   range_in      in   [1:0] 00 low, 01 mid, 10 high, 11 illegal
//   clr_err       in   clears illegal_seen (a same-cycle illegal sample wins)
//   stable_range  out  [1:0] committed range code
//   change_pulse  out  one-cycle pulse after each commit
//   change_up     out  1 when the last commit raised the code
//   pending       out  a candidate code is being qualified
//   illegal_seen  out  sticky flag, set by a valid 2'b11 sample
//   change_count  out  [7:0] saturating commit counter
//
// Build option
//   RANGE_FILTER_STATS_EN  defined: change_count counts commits, saturating
//                          at 255. Undefined: change_count is tied to 0.
// -----------------------------------------------------------------------------
module range_persistence_filter #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_en,
  input  logic [1:0] range_in,
  input  logic       clr_err,
  output logic [1:0] stable_range,
  output logic       change_pulse,
  output logic       change_up,
  output logic       pending,
  output logic       illegal_seen,
  output logic [7:0] change_count
);

  // FSM encoding
  localparam logic [0:0] ST_STABLE = 1'b0;
  localparam logic [0:0] ST_CAND   = 1'b1;

  localparam logic [1:0]       CODE_ILLEGAL = 2'b11;
  localparam logic [1:0]       CODE_RESET   = 2'b00;
  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(HOLD_CYCLES - 1);

  // Elaboration guard: the counter must be able to reach HOLD_CYCLES-1 and
  // HOLD_CYCLES must be at least 2 so commits can never be back to back.
  generate
    if ((HOLD_CYCLES < 2) || (HOLD_CYCLES >= (2 ** CNT_W))) begin : g_bad_hold_cycles
      $error("range_persistence_filter: HOLD_CYCLES out of range for CNT_W");
    end
  endgenerate

  // Registered state
  logic [0:0]       state;
  logic [1:0]       cand;
  logic [CNT_W-1:0] cnt;

  // Next-state values
  logic [0:0]       state_nxt;
  logic [1:0]       cand_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       stable_nxt;
  logic             up_nxt;
  logic             illegal_nxt;
  logic             commit;

  // Next-state and output decode
  always_comb begin
    state_nxt   = state;
    cand_nxt    = cand;
    cnt_nxt     = cnt;
    stable_nxt  = stable_range;
    up_nxt      = change_up;
    commit      = 1'b0;
    // Clear applies every cycle; an illegal sample below overrides it.
    illegal_nxt = illegal_seen & ~clr_err;

    if (sample_en) begin
      if (range_in == CODE_ILLEGAL) begin
        // Illegal codes only raise the flag; qualification is untouched.
        illegal_nxt = 1'b1;
      end else begin
        case (state)
          ST_STABLE: begin
            if (range_in != stable_range) begin
              state_nxt = ST_CAND;
              cand_nxt  = range_in;
              cnt_nxt   = CNT_ONE;
            end
          end
          ST_CAND: begin
            if (range_in == cand) begin
              if (cnt == CNT_LAST) begin
                commit     = 1'b1;
                stable_nxt = cand;
                up_nxt     = (cand > stable_range);
                state_nxt  = ST_STABLE;
                cnt_nxt    = CNT_ZERO;
              end else begin
                cnt_nxt = cnt + CNT_ONE;
              end
            end else if (range_in == stable_range) begin
              // Input fell back to the committed code: drop the candidate.
              state_nxt = ST_STABLE;
              cnt_nxt   = CNT_ZERO;
            end else begin
              // A third legal code: qualify it from scratch.
              cand_nxt = range_in;
              cnt_nxt  = CNT_ONE;
            end
          end
          default: begin
            state_nxt = ST_STABLE;
            cnt_nxt   = CNT_ZERO;
          end
        endcase
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_STABLE;
      cand         <= CODE_RESET;
      cnt          <= CNT_ZERO;
      stable_range <= CODE_RESET;
      change_pulse <= 1'b0;
      change_up    <= 1'b0;
      pending      <= 1'b0;
      illegal_seen <= 1'b0;
    end else begin
      state        <= state_nxt;
      cand         <= cand_nxt;
      cnt          <= cnt_nxt;
      stable_range <= stable_nxt;
      change_pulse <= commit;
      change_up    <= up_nxt;
      pending      <= (state_nxt == ST_CAND);
      illegal_seen <= illegal_nxt;
    end
  end

`ifdef RANGE_FILTER_STATS_EN
  // Saturating commit counter, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      change_count <= 8'd0;
    end else if (commit && (change_count != 8'd255)) begin
      change_count <= change_count + 8'd1;
    end
  end
`else
  assign change_count = 8'd0;
`endif

endmodule

// File: tb/tb_range_persistence_filter.sv
// -----------------------------------------------------------------------------
// tb_range_persistence_filter
//   Scoreboard bench: each driven cycle runs a reference model whose
//   expected outputs are queued, then popped and compared one cycle later.
// -----------------------------------------------------------------------------
module tb_range_persistence_filter;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_en;
  logic [1:0] range_in;
  logic       clr_err;
  logic [1:0] stable_range;
  logic       change_pulse;
  logic       change_up;
  logic       pending;
  logic       illegal_seen;
  logic [7:0] change_count;

  range_persistence_filter #(.HOLD_CYCLES(HOLD), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_en    (sample_en),
    .range_in     (range_in),
    .clr_err      (clr_err),
    .stable_range (stable_range),
    .change_pulse (change_pulse),
    .change_up    (change_up),
    .pending      (pending),
    .illegal_seen (illegal_seen),
    .change_count (change_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic       pulse;
    logic       up;
    logic       pend;
    logic       ill;
    logic [7:0] count;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic       m_cand_active;
  logic [1:0] m_cand;
  int         m_cnt;
  logic [1:0] m_stable;
  logic       m_pulse;
  logic       m_up;
  logic       m_ill;
  int         m_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic en, input logic [1:0] rin,
                            input logic clr);
    if (r) begin
      m_cand_active = 1'b0;
      m_cand = 2'b00; m_cnt = 0; m_stable = 2'b00;
      m_pulse = 1'b0; m_up = 1'b0; m_ill = 1'b0; m_count = 0;
    end else begin
      m_pulse = 1'b0;
      if (clr) m_ill = 1'b0;
      if (en) begin
        if (rin == 2'b11) begin
          m_ill = 1'b1;
        end else if (!m_cand_active) begin
          if (rin != m_stable) begin
            m_cand_active = 1'b1; m_cand = rin; m_cnt = 1;
          end
        end else if (rin == m_cand) begin
          m_cnt = m_cnt + 1;
          if (m_cnt == HOLD) begin
            m_up = (m_cand > m_stable);
            m_stable = m_cand;
            m_cand_active = 1'b0;
            m_cnt = 0;
            m_pulse = 1'b1;
`ifdef RANGE_FILTER_STATS_EN
            if (m_count < 255) m_count = m_count + 1;
`endif
          end
        end else if (rin == m_stable) begin
          m_cand_active = 1'b0; m_cnt = 0;
        end else begin
          m_cand = rin; m_cnt = 1;
        end
      end
    end
  endtask

  // Drive one cycle, queue the model's prediction, compare after the edge.
  task automatic step(input logic r, input logic en, input logic [1:0] rin,
                      input logic clr);
    exp_t e;
    @(negedge clk);
    rst = r; sample_en = en; range_in = rin; clr_err = clr;
    model_step(r, en, rin, clr);
    e.st = m_stable; e.pulse = m_pulse; e.up = m_up; e.pend = m_cand_active;
    e.ill = m_ill; e.count = 8'(m_count);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("stable_range", 32'(stable_range), 32'(e.st));
      check("change_pulse", 32'(change_pulse), 32'(e.pulse));
      check("change_up",    32'(change_up),    32'(e.up));
      check("pending",      32'(pending),      32'(e.pend));
      check("illegal_seen", 32'(illegal_seen), 32'(e.ill));
      check("change_count", 32'(change_count), 32'(e.count));
    end
  endtask

  task automatic feed(input logic [1:0] rin, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, rin, 1'b0);
  endtask

  initial begin
    logic [1:0] tgt;
    rst = 1'b1; sample_en = 1'b0; range_in = 2'b00; clr_err = 1'b0;

    // 1: reset, then 01 x4 commits with an upward pulse
    step(1'b1, 1'b0, 2'b00, 1'b0);
    check("t1_reset_stable", 32'(stable_range), 32'd0);
    check("t1_reset_pending", 32'(pending), 32'd0);
    feed(2'b01, 1);
    check("t1_pending_1st", 32'(pending), 32'd1);
    feed(2'b01, 3);
    check("t1_stable", 32'(stable_range), 32'd1);
    check("t1_pulse", 32'(change_pulse), 32'd1);
    check("t1_up", 32'(change_up), 32'd1);
    feed(2'b01, 1);
    check("t1_pulse_drop", 32'(change_pulse), 32'd0);

    // 2: 10,10,10 then 01 aborts
    feed(2'b10, 3);
    feed(2'b01, 1);
    check("t2_stable", 32'(stable_range), 32'd1);
    check("t2_pending", 32'(pending), 32'd0);
    check("t2_pulse", 32'(change_pulse), 32'd0);

    // 3: from 00, 01,01 then 10 x4 restarts and commits on the 6th edge
    step(1'b1, 1'b0, 2'b00, 1'b0);
    feed(2'b01, 2);
    feed(2'b10, 3);
    check("t3_before_commit", 32'(stable_range), 32'd0);
    feed(2'b10, 1);
    check("t3_stable", 32'(stable_range), 32'd2);
    check("t3_pulse", 32'(change_pulse), 32'd1);

    // 4: gap in sample_en and an illegal sample do not break the run
    step(1'b1, 1'b0, 2'b00, 1'b0);
    feed(2'b01, 2);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2'b10, 1'b0);
    feed(2'b11, 1);
    check("t4_illegal_set", 32'(illegal_seen), 32'd1);
    check("t4_still_pending", 32'(pending), 32'd1);
    feed(2'b01, 1);
    check("t4_not_yet", 32'(stable_range), 32'd0);
    feed(2'b01, 1);
    check("t4_commit", 32'(stable_range), 32'd1);
    step(1'b0, 1'b1, 2'b11, 1'b1);
    check("t4_set_wins", 32'(illegal_seen), 32'd1);
    step(1'b0, 1'b0, 2'b01, 1'b1);
    check("t4_cleared", 32'(illegal_seen), 32'd0);

    // 5: reset mid-qualification (cnt=3), then a fresh run from cnt=1
    step(1'b1, 1'b0, 2'b00, 1'b0);
    feed(2'b01, 3);
    step(1'b1, 1'b1, 2'b01, 1'b0);
    check("t5_reset_pending", 32'(pending), 32'd0);
    check("t5_reset_stable", 32'(stable_range), 32'd0);
    feed(2'b01, 3);
    check("t5_no_early_commit", 32'(stable_range), 32'd0);
    feed(2'b01, 1);
    check("t5_commit", 32'(stable_range), 32'd1);

    // Random stress against the model
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));

    // 6: 300 alternating commits saturate the counter (or keep it 0)
    step(1'b1, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 300; i++) begin
      tgt = (m_stable == 2'b00) ? 2'b10 : 2'b00;
      feed(tgt, HOLD);
    end
`ifdef RANGE_FILTER_STATS_EN
    check("t6_count_sat", 32'(change_count), 32'd255);
`else
    check("t6_count_zero", 32'(change_count), 32'd0);
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
